// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage with PC register and IF/ID pipeline register.
// Optional macro FETCH_MISALIGN_CHECK_EN adds misalign_f and bubbles misaligned fetches.
module fetch_stage #(
    parameter int unsigned      Width     = 32,
    parameter logic [Width-1:0] RESET_PC  = '0,
    parameter logic [Width-1:0] NOP_INSTR = Width'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             flush_d,
    input  logic             pc_src_e,
    input  logic [Width-1:0] pc_target_e,
    output logic [Width-1:0] imem_addr,
    input  logic [Width-1:0] imem_rd,
    output logic [Width-1:0] pc_f,
    output logic [Width-1:0] instr_d,
    output logic [Width-1:0] pc_d,
    output logic [Width-1:0] pc_plus4_d,
    output logic             valid_d
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic             misalign_f
`endif
);

    logic [Width-1:0] pc_f_q, pc_f_d;
    logic [Width-1:0] instr_d_q, instr_d_d;
    logic [Width-1:0] pc_d_q, pc_d_d;
    logic [Width-1:0] pc4_d_q, pc4_d_d;
    logic             valid_d_q, valid_d_d;
    logic [Width-1:0] pc_plus4_f;
    logic [Width-1:0] pc_next;
    logic             bubble_f;

    assign pc_plus4_f = pc_f_q + Width'(4);
    assign pc_next    = pc_src_e ? pc_target_e : pc_plus4_f;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_q, mis_d;

    always_comb begin
        mis_d = mis_q;
        if (pc_src_e) mis_d = (pc_target_e[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) mis_q <= 1'b0;
        else        mis_q <= mis_d;
    end

    assign bubble_f   = mis_q;
    assign misalign_f = mis_q;
`else
    assign bubble_f = 1'b0;
`endif

    // A redirect must never be lost, so it outranks stall_f.
    always_comb begin
        pc_f_d = pc_f_q;
        if (pc_src_e || !stall_f) pc_f_d = pc_next;
    end

    always_comb begin
        instr_d_d = instr_d_q;
        pc_d_d    = pc_d_q;
        pc4_d_d   = pc4_d_q;
        valid_d_d = valid_d_q;
        if (flush_d || (!stall_d && bubble_f)) begin
            instr_d_d = NOP_INSTR;
            pc_d_d    = '0;
            pc4_d_d   = '0;
            valid_d_d = 1'b0;
        end else if (!stall_d) begin
            instr_d_d = imem_rd;
            pc_d_d    = pc_f_q;
            pc4_d_d   = pc_plus4_f;
            valid_d_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_f_q    <= RESET_PC;
            instr_d_q <= NOP_INSTR;
            pc_d_q    <= '0;
            pc4_d_q   <= '0;
            valid_d_q <= 1'b0;
        end else begin
            pc_f_q    <= pc_f_d;
            instr_d_q <= instr_d_d;
            pc_d_q    <= pc_d_d;
            pc4_d_q   <= pc4_d_d;
            valid_d_q <= valid_d_d;
        end
    end

    assign pc_f       = pc_f_q;
    assign imem_addr  = pc_f_q;
    assign instr_d    = instr_d_q;
    assign pc_d       = pc_d_q;
    assign pc_plus4_d = pc4_d_q;
    assign valid_d    = valid_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: randomized and directed stimulus vs. a reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pc4;
        logic        v;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_f = 1'b0;
    logic        stall_d = 1'b0;
    logic        flush_d = 1'b0;
    logic        pc_src_e = 1'b0;
    logic [31:0] pc_target_e = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        mis_o;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    // reference model state (architectural view)
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pc4;
    logic        m_v;
    logic        m_mis = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:2] == 30'd0) return 32'h0050_0113;
        return (a[31:2] * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rd = mem_word(imem_addr);

    fetch_stage dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall_f(stall_f),
        .stall_d(stall_d),
        .flush_d(flush_d),
        .pc_src_e(pc_src_e),
        .pc_target_e(pc_target_e),
        .imem_addr(imem_addr),
        .imem_rd(imem_rd),
        .pc_f(pc_f),
        .instr_d(instr_d),
        .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d),
        .valid_d(valid_d)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_f(mis_o)
`endif
    );

`ifndef FETCH_MISALIGN_CHECK_EN
    assign mis_o = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and push what the outputs must be after the edge.
    task automatic step(input logic rst, input logic sf, input logic sd,
                        input logic fl, input logic src,
                        input logic [31:0] tgt);
        exp_t e;
        logic bub;
        @(negedge clk);
        rst_n = rst; stall_f = sf; stall_d = sd;
        flush_d = fl; pc_src_e = src; pc_target_e = tgt;
        if (!rst) begin
            m_pc = 32'h0; m_instr = NOP; m_pcd = 0; m_pc4 = 0;
            m_v = 0; m_mis = 0;
        end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
            bub = m_mis;
`else
            bub = 1'b0;
`endif
            if (fl || (!sd && bub)) begin
                m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_v = 0;
            end else if (!sd) begin
                m_instr = mem_word(m_pc); m_pcd = m_pc;
                m_pc4 = m_pc + 4; m_v = 1;
            end
            if (src) begin
                m_pc = tgt;
                m_mis = (tgt % 4) != 0;
            end else if (!sf) begin
                m_pc = m_pc + 4;
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.pcd = m_pcd;
        e.pc4 = m_pc4; e.v = m_v;
`ifdef FETCH_MISALIGN_CHECK_EN
        e.mis = m_mis;
`else
        e.mis = 1'b0;
`endif
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic run_to(input logic [31:0] pc);
        int k = 0;
        while (m_pc != pc && k < 40) begin
            step(1, 0, 0, 0, 0, 0);
            k++;
        end
        if (m_pc != pc) begin
            failures++;
            $display("FAIL run_to actual=%08h required=%08h", m_pc, pc);
        end
    endtask

    // monitor: compare outputs shortly after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_f", pc_f, e.pc);
                chk("imem_addr", imem_addr, e.pc);
                chk("instr_d", instr_d, e.instr);
                chk("pc_d", pc_d, e.pcd);
                chk("pc_plus4_d", pc_plus4_d, e.pc4);
                chk("valid_d", {31'd0, valid_d}, {31'd0, e.v});
                chk("misalign_f", {31'd0, mis_o}, {31'd0, e.mis});
            end
        end
    end

    initial begin
        logic [31:0] t;
        int r;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        run_to(32'd12);
        step(1, 1, 1, 0, 0, 0);
        run(1);
        run_to(32'd20);
        step(1, 1, 0, 1, 1, 32'h40);
        run(2);
        step(1, 0, 0, 1, 1, 32'hFFFF_FFFC);
        run(2);
        step(0, 0, 0, 0, 1, 32'h80);
        run(2);
        step(1, 0, 0, 1, 1, 32'h42);
        run(2);
        step(1, 0, 0, 1, 1, 32'h44);
        run(2);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 31);
            t = $urandom;
            if (r < 2) t[1:0] = 2'b00;
            if (r == 0)
                step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1, t);
            else if (r < 5)
                step(1, 1, 1, 0, 0, t);
            else if (r < 9)
                step(1, 1'($urandom), 0, 1, 1, t);
            else if (r == 9)
                step(1, 0, 1, 0, 0, t);
            else if (r == 10)
                step(1, 0, 0, 1, 0, t);
            else if (r == 11)
                step(1, 1, 0, 0, 0, t);
            else
                step(1, 0, 0, 0, 0, t);
        end
        @(posedge clk);
        #3;
        chk("drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
